// File: rtl/vlc_pkg.sv
// Shared VLC definitions: frame states, framing bytes and the Manchester chip convention.
// The future vlc_manchester_rx uses the same package.
package vlc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    GAP
  } vlc_state_t;

  localparam logic [7:0] VLC_PREAMBLE = 8'h55;
  localparam logic [7:0] VLC_SFD      = 8'hD5;

  // Line level of the first chip of a '1' bit; the second chip is always its complement.
  localparam logic VLC_CHIP0_OF_ONE = 1'b0;

  function automatic logic chip_level(input logic bit_val, input logic second);
    return (bit_val ~^ VLC_CHIP0_OF_ONE) ^ second;
  endfunction

endpackage

// File: rtl/vlc_manchester_tx_if.sv
// Byte stream from the Nios-side buffer into the VLC transmitter (valid/ready).
interface vlc_manchester_tx_if;

  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_last, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_last, input tx_valid, output tx_ready);

endinterface

// File: rtl/vlc_chip_timer.sv
// Divides clk into Manchester chips: one chip_tick per CLK_DIV cycles while enabled,
// with chip_phase telling whether the current chip is the first or second of its bit.
module vlc_chip_timer #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic chip_tick,
  output logic chip_phase
);

  localparam int              CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign chip_tick = en & (count == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      chip_phase <= 1'b0;
    end else if (clear) begin
      count      <= '0;
      chip_phase <= 1'b0;
    end else if (en) begin
      if (count == CNT_LAST) begin
        count      <= '0;
        chip_phase <= ~chip_phase;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vlc_manchester_tx.sv
// VLC transmitter: frames stream bytes as preamble + SFD + payload, Manchester-encodes
// them MSB first onto the LED line and forces an idle gap after every frame.
module vlc_manchester_tx
  import vlc_pkg::*;
#(
  parameter int   CLK_DIV    = 50,
  parameter int   PRE_BYTES  = 2,
  parameter int   GAP_BITS   = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                istart,
  vlc_manchester_tx_if.slave  tx,
  output logic                led_out,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun
);

  localparam int GAP_CHIPS = (GAP_BITS > 0) ? 2 * GAP_BITS : 1;
  localparam int BYTE_W    = $clog2(PRE_BYTES + 1);
  localparam int GAP_W     = $clog2(GAP_CHIPS + 1);
  localparam logic [BYTE_W-1:0] PRE_LAST = BYTE_W'(PRE_BYTES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CHIPS - 1);

  vlc_state_t        state;
  logic [7:0]        hold_data;
  logic              hold_last;
  logic              full;
  logic [7:0]        shreg;
  logic              cur_last;
  logic              und_flag;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              chip_tick;
  logic              chip_phase;
  logic              accept;
  logic              start;
  logic              bit_end;
  logic              byte_end;
  logic              load;

  vlc_chip_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (busy),
    .clear      (~busy),
    .chip_tick  (chip_tick),
    .chip_phase (chip_phase)
  );

  assign tx.tx_ready = ~full;
  assign accept      = tx.tx_valid & ~full;
  assign start       = (state == IDLE) & istart & full;
  assign bit_end     = chip_tick & chip_phase &
                       ((state == PREAMBLE) | (state == SFD) | (state == DATA));
  assign byte_end    = bit_end & (bit_cnt == 3'd7);
  // Shifter takes the held byte after the SFD, or seamlessly between payload bytes.
  assign load        = byte_end & ((state == SFD) | ((state == DATA) & ~cur_last & full));

  // Data registers carry no reset; validity is tracked by full and the FSM.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= tx.tx_data;
      hold_last <= tx.tx_last;
    end
    if (start) begin
      shreg <= VLC_PREAMBLE;
    end else if (load) begin
      shreg <= hold_data;
    end else if (byte_end && (state == PREAMBLE)) begin
      shreg <= (byte_cnt == PRE_LAST) ? VLC_SFD : VLC_PREAMBLE;
    end else if (bit_end) begin
      shreg <= {shreg[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
    end else begin
      full <= (full & ~load) | accept;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      led_out    <= IDLE_LEVEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      cur_last   <= 1'b0;
      und_flag   <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= PREAMBLE;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            und_flag <= 1'b0;
            led_out  <= chip_level(VLC_PREAMBLE[7], 1'b0);
          end
        end
        PREAMBLE, SFD, DATA: begin
          if (chip_tick && !chip_phase) begin
            led_out <= chip_level(shreg[7], 1'b1);
          end else if (chip_tick && bit_cnt != 3'd7) begin
            bit_cnt <= bit_cnt + 3'd1;
            led_out <= chip_level(shreg[6], 1'b0);
          end else if (chip_tick) begin
            bit_cnt <= '0;
            if (state == PREAMBLE) begin
              if (byte_cnt == PRE_LAST) begin
                state   <= SFD;
                led_out <= chip_level(VLC_SFD[7], 1'b0);
              end else begin
                byte_cnt <= byte_cnt + BYTE_W'(1);
                led_out  <= chip_level(VLC_PREAMBLE[7], 1'b0);
              end
            end else if (state == SFD || (!cur_last && full)) begin
              state    <= DATA;
              cur_last <= hold_last;
              led_out  <= chip_level(hold_data[7], 1'b0);
            end else begin
              // Either the frame ended cleanly or the source starved us mid-frame.
              state    <= GAP;
              gap_cnt  <= '0;
              led_out  <= IDLE_LEVEL;
              underrun <= ~cur_last;
              und_flag <= ~cur_last;
            end
          end
        end
        GAP: begin
          if (chip_tick) begin
            if (gap_cnt == GAP_LAST) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= ~und_flag;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          led_out <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vlc_manchester_tx.sv
// Directed bench for vlc_manchester_tx: a line decoder recovers bytes from led_out and
// checks them against a queue of expected frame bytes filled as stimulus is driven.
module tb_vlc_manchester_tx;

  localparam int CLK_DIV   = 4;
  localparam int PRE_BYTES = 2;
  localparam int GAP_BITS  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic istart = 1'b0;
  logic led_out, busy, frame_done, underrun;

  vlc_manchester_tx_if tx_if ();

  vlc_manchester_tx #(
    .CLK_DIV   (CLK_DIV),
    .PRE_BYTES (PRE_BYTES),
    .GAP_BITS  (GAP_BITS),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .istart     (istart),
    .tx         (tx_if),
    .led_out    (led_out),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] acc, exp_b;
  logic       c0;
  logic       gap_seen;
  int cyc = 0, nbits = 0, busy_len = 0, last_busy_len = 0, fd_cnt = 0, ur_cnt = 0;
  int fd0, ur0;

  // Line decoder: samples mid-chip while busy; a pair of equal chips marks the gap.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (underrun) ur_cnt++;
    if (!busy) begin
      if (busy_len != 0) last_busy_len = busy_len;
      busy_len = 0; cyc = 0; nbits = 0; gap_seen = 1'b0;
    end else begin
      busy_len++;
      if (!gap_seen && (cyc % CLK_DIV) == CLK_DIV / 2) begin
        if (((cyc / CLK_DIV) % 2) == 0) begin
          c0 = led_out;
        end else if (c0 == led_out) begin
          gap_seen = 1'b1;
        end else begin
          acc = {acc[6:0], led_out};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            n_tests++;
            if (exp_q.size() != 0) exp_b = exp_q.pop_front();
            else exp_b = 8'hxx;
            assert (acc === exp_b) else begin
              n_fail++;
              $error("FAIL decoded_byte: got %02h expected %02h", acc, exp_b);
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    tx_if.tx_data  = d;
    tx_if.tx_last  = l;
    tx_if.tx_valid = 1'b1;
    while (!tx_if.tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", (t < 2000), 1);
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int max_cyc, input string tag);
    int t = 0;
    while (busy !== val && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    check(tag, (busy === val), 1);
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int n);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    exp_q.push_back(b0);
    if (n > 1) exp_q.push_back(b1);
    if (n > 2) exp_q.push_back(b2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_last  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_state", {led_out, tx_if.tx_ready, busy}, 3'b010);
    end

    // Single byte frame
    fd0 = fd_cnt; ur0 = ur_cnt;
    istart = 1'b1;
    push_frame(8'hA5, 8'h00, 8'h00, 1);
    send_byte(8'hA5, 1'b1);
    wait_busy(1'b1, 10, "t2_start");
    wait_busy(1'b0, 1000, "t2_end");
    repeat (3) @(negedge clk);
    check("t2_frame_done", fd_cnt - fd0, 1);
    check("t2_underrun", ur_cnt - ur0, 0);
    check("t2_busy_len", last_busy_len, 272);
    check("t2_queue", exp_q.size(), 0);

    // Held byte with istart low, then enable
    istart = 1'b0;
    fd0 = fd_cnt;
    send_byte(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("t3_no_start", {busy, led_out, tx_if.tx_ready}, 3'b000);
    push_frame(8'h3C, 8'h00, 8'h00, 1);
    istart = 1'b1;
    @(negedge clk);
    check("t3_latency_busy", busy, 1);
    check("t3_first_chip", led_out, 1);
    wait_busy(1'b0, 1000, "t3_end");
    repeat (3) @(negedge clk);
    check("t3_frame_done", fd_cnt - fd0, 1);
    check("t3_busy_len", last_busy_len, 272);
    check("t3_queue", exp_q.size(), 0);

    // Three back-to-back bytes
    fd0 = fd_cnt; ur0 = ur_cnt;
    push_frame(8'h01, 8'h80, 8'hFF, 3);
    send_byte(8'h01, 1'b0);
    send_byte(8'h80, 1'b0);
    send_byte(8'hFF, 1'b1);
    wait_busy(1'b0, 2000, "t4_end");
    repeat (3) @(negedge clk);
    check("t4_frame_done", fd_cnt - fd0, 1);
    check("t4_underrun", ur_cnt - ur0, 0);
    check("t4_busy_len", last_busy_len, 400);
    check("t4_queue", exp_q.size(), 0);

    // Underrun: second byte arrives too late; istart dropped mid-frame
    fd0 = fd_cnt; ur0 = ur_cnt;
    push_frame(8'h11, 8'h00, 8'h00, 1);
    send_byte(8'h11, 1'b0);
    wait_busy(1'b1, 10, "t5_start");
    istart = 1'b0;
    wait_busy(1'b0, 1000, "t5_end");
    repeat (3) @(negedge clk);
    check("t5_underrun", ur_cnt - ur0, 1);
    check("t5_frame_done", fd_cnt - fd0, 0);
    check("t5_busy_len", last_busy_len, 272);
    check("t5_queue", exp_q.size(), 0);
    send_byte(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    check("t5_held", {busy, tx_if.tx_ready}, 2'b00);

    // Reset in the middle of the payload
    push_frame(8'h22, 8'h00, 8'h00, 1);
    istart = 1'b1;
    wait_busy(1'b1, 10, "t6_start");
    repeat (200) @(negedge clk);
    send_byte(8'h77, 1'b0);
    check("t6_ready_before", tx_if.tx_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_reset", {led_out, tx_if.tx_ready, busy}, 3'b010);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    fd0 = fd_cnt; ur0 = ur_cnt;
    repeat (5) @(negedge clk);
    check("t6_after_reset", {led_out, tx_if.tx_ready, busy}, 3'b010);
    push_frame(8'h5A, 8'h00, 8'h00, 1);
    send_byte(8'h5A, 1'b1);
    wait_busy(1'b1, 10, "t6_restart");
    wait_busy(1'b0, 1000, "t6_end");
    repeat (3) @(negedge clk);
    check("t6_frame_done", fd_cnt - fd0, 1);
    check("t6_underrun", ur_cnt - ur0, 0);
    check("t6_busy_len", last_busy_len, 272);
    check("t6_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
